// File: rtl/jpg_axi_wsink.sv
// AXI3 write sink for the jpgenc bitstream: byte-strobed RAM, B responses, byte counter, protocol flag.
// Optional define WSINK_OOB_CHK_EN: drop beats past the top of RAM and answer SLVERR instead of wrapping.
module jpg_axi_wsink #(
    parameter int  DEPTH = 1024,
    parameter int  IDW   = 4,
    parameter int  LENW  = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            awvalid,
    output logic            awready,
    input  logic [31:0]     awaddr,
    input  logic [LENW-1:0] awlen,
    input  logic [IDW-1:0]  awid,
    input  logic            wvalid,
    output logic            wready,
    input  logic [127:0]    wdata,
    input  logic [15:0]     wstrb,
    input  logic            wlast,
    input  logic [IDW-1:0]  wid,
    output logic            bvalid,
    input  logic            bready,
    output logic [IDW-1:0]  bid,
    output logic [1:0]      bresp,
    input  logic            clrCnt,
    input  logic [AW-1:0]   dbgAddr,
    output logic [127:0]    dbgData,
    output logic [31:0]     byteCnt,
    output logic            protErr
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [LENW-1:0] len_q, len_d;
    logic [LENW-1:0] beat_q, beat_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            wrap_q, wrap_d;
    logic            oob_q, oob_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            perr_q, perr_d;
    logic [127:0]    dbg_q, dbg_d;

    logic [127:0]    mem [DEPTH];

    logic            beat_fire;
    logic            beat_wr;
    logic            at_len;
    logic            beat_err;
    logic [4:0]      pop;
    logic [32:0]     sum;
    logic            unused_addr;

    assign unused_addr = ^{awaddr[31:AW+4], awaddr[3:0]};

    assign awready   = (state_q == S_IDLE) && !rst;
    assign wready    = (state_q == S_DATA) && !rst;
    assign bvalid    = (state_q == S_RESP) && !rst;
    assign bid       = id_q;
    assign bresp     = bvalid ? {oob_q, 1'b0} : 2'b00;
    assign byteCnt   = cnt_q;
    assign protErr   = perr_q;
    assign dbgData   = dbg_q;

    assign beat_fire = wvalid && wready;
    assign at_len    = (beat_q == len_q);
    assign beat_err  = (wlast != at_len) || (wid != id_q);
`ifdef WSINK_OOB_CHK_EN
    // wrap_q marks that start+beat has run past the last word
    assign beat_wr   = beat_fire && !wrap_q;
`else
    assign beat_wr   = beat_fire;
`endif
    assign pop       = beat_wr ? 5'($countones(wstrb)) : 5'd0;
    assign sum       = {1'b0, (clrCnt ? 32'd0 : cnt_q)} + 33'(pop);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        id_d    = id_q;
        wrap_d  = wrap_q;
        oob_d   = oob_q;
        cnt_d   = cnt_q;
        perr_d  = perr_q;
        dbg_d   = mem[dbgAddr];

        case (state_q)
            S_IDLE: begin
                if (awvalid && awready) begin
                    ptr_d   = awaddr[AW+3:4];
                    len_d   = awlen;
                    id_d    = awid;
                    beat_d  = '0;
                    wrap_d  = 1'b0;
                    oob_d   = 1'b0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (beat_fire) begin
                    ptr_d  = ptr_q + 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (ptr_q == '1) wrap_d = 1'b1;
                    if (!beat_wr) oob_d = 1'b1;
                    if (wlast || at_len) state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // a clear coinciding with a beat keeps only that beat's contribution
        if (beat_fire) begin
            cnt_d  = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
            perr_d = (clrCnt ? 1'b0 : perr_q) | beat_err;
        end else if (clrCnt) begin
            cnt_d  = '0;
            perr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            id_q    <= '0;
            wrap_q  <= 1'b0;
            oob_q   <= 1'b0;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
            dbg_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            id_q    <= id_d;
            wrap_q  <= wrap_d;
            oob_q   <= oob_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
            dbg_q   <= dbg_d;
        end
    end

    // RAM is never cleared; reset only blocks writes through wready
    always_ff @(posedge clk) begin
        if (beat_wr) begin
            for (int b = 0; b < 16; b++) begin
                if (wstrb[b]) mem[ptr_q][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

endmodule
